firmware_reader: RTL and testbench

//   Bus initiator for the firmware ROM: drives address/SELECT_firmware/SELECT_vectors and samples the ROM data bus.

---
 rtl/firmware_reader.sv | 144 ++++++++++++++
 tb/tb_firmware_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/firmware_reader.sv
// Firmware ROM bus initiator: reads a firmware block or the 6-byte vector table and streams the bytes out.
// Optional feature macro FIRMWARE_READER_CHECKSUM_EN adds an 8-bit running sum of the streamed bytes.
module firmware_reader #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              vec_mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W:0]   length,
  output logic [15:0]       address,
  output logic              SELECT_firmware,
  output logic              SELECT_vectors,
  input  logic [7:0]        data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef FIRMWARE_READER_CHECKSUM_EN
  output logic              done,
  output logic [7:0]        checksum
`else
  output logic              done
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, PRESENT, FINISH} state_t;

  localparam logic [15:0]     VEC_BASE  = 16'hFFFA;
  localparam logic [ADDR_W:0] VEC_COUNT = (ADDR_W+1)'(6);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [3:0]      WAIT_LAST = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic                vec_q, vec_d;
  logic [15:0]         addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [3:0]          wait_q, wait_d;
  logic [7:0]          out_data_q, out_data_d;
  logic [ADDR_W-1:0]   blk_next;
  logic [15:0]         addr_next;

  // Block reads wrap inside the firmware ROM; vector reads just count up to 0xFFFF.
  assign blk_next  = addr_q[ADDR_W-1:0] + ADDR_W'(1);
  assign addr_next = vec_q ? (addr_q + 16'd1) : 16'(blk_next);

`ifdef FIRMWARE_READER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wait_d     = wait_q;
    out_data_d = out_data_q;
`ifdef FIRMWARE_READER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = vec_mode;
          wait_d  = 4'd0;
          count_d = vec_mode ? VEC_COUNT : length;
`ifdef FIRMWARE_READER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
          if (!vec_mode && length == '0) begin
            state_d = FINISH;
          end else begin
            state_d = ACCESS;
            addr_d  = vec_mode ? VEC_BASE : 16'(src_addr);
          end
        end
      end
      ACCESS: begin
        if (wait_q == WAIT_LAST) begin
          out_data_d = data;
          state_d    = PRESENT;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      PRESENT: begin
        // Stall here without touching the bus until the consumer takes the byte.
        if (out_ready) begin
          count_d = count_q - CNT_ONE;
`ifdef FIRMWARE_READER_CHECKSUM_EN
          sum_d   = sum_q + out_data_q;
`endif
          if (count_q == CNT_ONE) begin
            state_d = FINISH;
          end else begin
            state_d = ACCESS;
            addr_d  = addr_next;
            wait_d  = 4'd0;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= 1'b0;
      addr_q     <= 16'd0;
      count_q    <= '0;
      wait_q     <= 4'd0;
      out_data_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      out_data_q <= out_data_d;
    end
  end

`ifdef FIRMWARE_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= 8'd0;
    else        sum_q <= sum_d;
  end

  assign checksum = sum_q;
`endif

  assign address         = addr_q;
  assign SELECT_firmware = (state_q == ACCESS) && !vec_q;
  assign SELECT_vectors  = (state_q == ACCESS) && vec_q;
  assign out_data        = out_data_q;
  assign out_valid       = (state_q == PRESENT);
  assign busy            = (state_q == ACCESS) || (state_q == PRESENT);
  assign done            = (state_q == FINISH);

endmodule

// File: tb/tb_firmware_reader.sv
// Directed bench for firmware_reader: ROM model with access-time gating, table of transfers, reset corner cases.
`timescale 1ns/1ps
module tb_firmware_reader;
  localparam int W = 1;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, vec_mode = 1'b0, out_ready = 1'b1;
  logic [13:0] src_addr = '0;
  logic [14:0] length = '0;
  logic [15:0] address;
  logic        sel_fw, sel_vec, out_valid, busy, done;
  logic [7:0]  data, out_data;
`ifdef FIRMWARE_READER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  firmware_reader #(.WAIT_CYCLES(W), .ADDR_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_mode(vec_mode),
    .src_addr(src_addr), .length(length), .address(address),
    .SELECT_firmware(sel_fw), .SELECT_vectors(sel_vec), .data(data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy),
`ifdef FIRMWARE_READER_CHECKSUM_EN
    .done(done), .checksum(checksum)
`else
    .done(done)
`endif
  );

  // ROM model: data is only meaningful once the select has been held for W cycles.
  logic [7:0] rom  [0:16383];
  logic [7:0] vtab [0:5];
  int hold_cnt = 0;
  always @(posedge clk) hold_cnt <= (sel_fw || sel_vec) ? hold_cnt + 1 : 0;
  always_comb begin
    data = 8'hEE;
    if (sel_fw && hold_cnt >= W)       data = rom[address[13:0]];
    else if (sel_vec && hold_cnt >= W) data = vtab[3'(address[2:0] - 3'd2)];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        vec;
    logic [13:0] src;
    logic [14:0] len;
    int          stall_byte;
    int          stall_cyc;
    int          extra_cyc;
    int          exp_first;
    int          exp_done;
  } row_t;

  task automatic do_read(input row_t t, output logic [7:0] cks_o);
    logic [7:0]  bytes_q[$];
    logic [15:0] addrs_q[$];
    int first = -1, donec = -1, ndone = 0, sel_cyc = 0, wrong_sel = 0, both = 0;
    int busy_at_done = 1, post_busy = 0, stall_bad = 0, hs_n = 0, busy1 = 0;
    int stall_left = t.stall_cyc;
    int nexp;
    logic prev_sel = 1'b0, sel;
    logic [7:0] held = 8'h00;
    cks_o = 8'h00;
    nexp = t.vec ? 6 : int'(t.len);
    @(negedge clk);
    vec_mode = t.vec; src_addr = t.src; length = t.len; start = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; busy1 = int'(busy); end
      if (c == t.extra_cyc) begin
        start = 1'b1; vec_mode = ~t.vec; src_addr = 14'h1555; length = 15'd1;
      end
      if (c == t.extra_cyc + 1) start = 1'b0;
      sel = sel_fw | sel_vec;
      if (sel_fw && sel_vec) both++;
      if (t.vec ? sel_fw : sel_vec) wrong_sel++;
      if (sel) sel_cyc++;
      if (sel && !prev_sel) addrs_q.push_back(address);
      prev_sel = sel;
      if (done) begin
        ndone++;
        if (donec < 0) begin
          donec = c; busy_at_done = int'(busy);
`ifdef FIRMWARE_READER_CHECKSUM_EN
          cks_o = checksum;
`endif
        end
      end
      if (donec >= 0 && c > donec && busy) post_busy++;
      if (out_valid) begin
        if (first < 0) first = c;
        if (hs_n == t.stall_byte && stall_left > 0) begin
          if (stall_left == t.stall_cyc) held = out_data;
          else if (out_data !== held) stall_bad++;
          if (sel) stall_bad++;
          out_ready = 1'b0; stall_left--;
        end else begin
          if (hs_n == t.stall_byte && t.stall_cyc > 0 && out_data !== held) stall_bad++;
          out_ready = 1'b1; bytes_q.push_back(out_data); hs_n++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (donec >= 0 && c >= donec + 3) break;
    end
    out_ready = 1'b1; start = 1'b0;
    chk({t.name, "_done_seen"}, int'(donec >= 0), 1);
    chk({t.name, "_nbytes"}, bytes_q.size(), nexp);
    chk({t.name, "_naddr"}, addrs_q.size(), nexp);
    for (int i = 0; i < nexp && i < bytes_q.size(); i++)
      chk($sformatf("%s_byte%0d", t.name, i), int'(bytes_q[i]),
          t.vec ? int'(vtab[i]) : int'(rom[(int'(t.src) + i) & 16'h3FFF]));
    for (int i = 0; i < nexp && i < addrs_q.size(); i++)
      chk($sformatf("%s_addr%0d", t.name, i), int'(addrs_q[i]),
          t.vec ? 16'hFFFA + i : ((int'(t.src) + i) & 16'h3FFF));
    chk({t.name, "_first_valid"}, first, t.exp_first);
    chk({t.name, "_done_cycle"}, donec, t.exp_done);
    chk({t.name, "_done_pulses"}, ndone, 1);
    chk({t.name, "_busy_at_done"}, busy_at_done, 0);
    chk({t.name, "_busy_after_start"}, busy1, int'(nexp != 0));
    chk({t.name, "_select_cycles"}, sel_cyc, nexp * (W + 1));
    chk({t.name, "_wrong_select"}, wrong_sel, 0);
    chk({t.name, "_both_selects"}, both, 0);
    chk({t.name, "_busy_after_done"}, post_busy, 0);
    chk({t.name, "_stall_stable"}, stall_bad, 0);
  endtask

  row_t tbl[7];
  logic [7:0] cks;
  int bad_done;

  initial begin
    for (int a = 0; a < 16384; a++) rom[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
    rom[256] = 8'h01; rom[257] = 8'hFF; rom[258] = 8'h10;
    vtab[0] = 8'h00; vtab[1] = 8'hE0; vtab[2] = 8'h34;
    vtab[3] = 8'h12; vtab[4] = 8'h00; vtab[5] = 8'hF0;

    //        name            vec   src       len     stall  cyc  extra first done
    tbl[0] = '{"blk4",        1'b0, 14'h0000, 15'd4,  -1,    0,   -1,   3,    13};
    tbl[1] = '{"vec6",        1'b1, 14'h1234, 15'd99, -1,    0,   -1,   3,    19};
    tbl[2] = '{"wrap",        1'b0, 14'h3FFE, 15'd4,  -1,    0,   -1,   3,    13};
    tbl[3] = '{"backpress",   1'b0, 14'h0040, 15'd4,  1,     10,  -1,   3,    23};
    tbl[4] = '{"len0",        1'b0, 14'h0000, 15'd0,  -1,    0,   -1,   -1,   1};
    tbl[5] = '{"start_busy",  1'b0, 14'h0200, 15'd4,  -1,    0,   5,    3,    13};
    tbl[6] = '{"start_final", 1'b0, 14'h0300, 15'd2,  -1,    0,   7,    3,    7};

    #12;
    chk("reset_address", int'(address), 0);
    chk("reset_sel_fw", int'(sel_fw), 0);
    chk("reset_sel_vec", int'(sel_vec), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
`ifdef FIRMWARE_READER_CHECKSUM_EN
    chk("reset_checksum", int'(checksum), 0);
`endif
    @(negedge clk); rst_n = 1'b1;

    for (int r = 0; r < 7; r++) begin
      do_read(tbl[r], cks);
      $display("transfer %s: checked, running mismatches %0d", tbl[r].name, n_bad);
    end

    // Reset during the ACCESS phase of the third byte.
    @(negedge clk);
    vec_mode = 1'b0; src_addr = 14'h0010; length = 15'd4; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    chk("midrst_in_access", int'(sel_fw), 1);
    chk("midrst_address", int'(address), 16'h0012);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_async_address", int'(address), 0);
    chk("midrst_async_sel_fw", int'(sel_fw), 0);
    chk("midrst_async_out_data", int'(out_data), 0);
    chk("midrst_async_out_valid", int'(out_valid), 0);
    chk("midrst_async_busy", int'(busy), 0);
    bad_done = int'(done);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bad_done += int'(done);
      if (c == 2) rst_n = 1'b1;
    end
    chk("midrst_no_done", bad_done, 0);
    do_read(tbl[0], cks);
    $display("transfer after_reset: checked, running mismatches %0d", n_bad);

    do_read('{"cks", 1'b0, 14'h0100, 15'd3, -1, 0, -1, 3, 10}, cks);
`ifdef FIRMWARE_READER_CHECKSUM_EN
    chk("checksum_at_done", int'(cks), 8'h10);
    chk("checksum_held", int'(checksum), 8'h10);
`endif
    $display("transfer cks: checked, running mismatches %0d", n_bad);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
